// File: rtl/parity_accum.sv
// Frame parity accumulator: XORs FRAME_LEN words into one parity bit and checks it against an expected value.
// Latency: done one edge after the last accepted word; valid low simply stalls ACCUM with no timeout.
module parity_accum #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           mode,
  input  logic                           exp_parity,
  input  logic                           valid,
  input  logic [WIDTH-1:0]               data,
  output logic                           ready,
  output logic                           busy,
  output logic                           done,
  output logic                           parity,
  output logic                           error,
  output logic [$clog2(FRAME_LEN+1)-1:0] word_count
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state;
  state_t state_nxt;
  logic   acc;
  logic   acc_nxt;
  logic   exp_q;
  logic   accept;
  logic   last_word;

  assign accept    = (state == ACCUM) && valid;
  assign last_word = accept && (word_count == LAST);
  assign acc_nxt   = acc ^ (^data);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (last_word) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Seeding acc with mode folds the odd-parity inversion into the running XOR,
  // so acc itself is the only copy of the latched mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= 1'b0;
      exp_q      <= 1'b0;
      parity     <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      if (state == IDLE && start) begin
        acc        <= mode;
        exp_q      <= exp_parity;
        word_count <= '0;
      end
      if (accept) begin
        acc        <= acc_nxt;
        word_count <= word_count + 1'b1;
      end
      if (last_word) begin
        parity <= acc_nxt;
        error  <= acc_nxt ^ exp_q;
      end
    end
  end

  assign ready = (state == ACCUM);
  assign busy  = (state == ACCUM) || (state == DONE);
  assign done  = (state == DONE);

endmodule
